// File: rtl/shared_data_memory.sv
// shared_data_memory: single-port data RAM shared by NUM_CORES cores via a round-robin arbiter.
// At most one access per clock; acks are one-cycle pulses and read data is registered per core.
module shared_data_memory #(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 1000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_write,
    input  logic [NUM_CORES*ADDR_W-1:0] core_address,
    input  logic [NUM_CORES*DATA_W-1:0] core_data_in,
    output logic [NUM_CORES-1:0]        core_ack,
    output logic [NUM_CORES-1:0]        core_err,
    output logic [NUM_CORES*DATA_W-1:0] core_data_out
);
    localparam int PTR_W = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
    localparam int MEM_AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]     ptr, gnt, idx, ptr_nxt;
    logic [NUM_CORES-1:0] elig;
    logic                 found, sel_write, in_range;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_data, rd_data;
    logic [MEM_AW-1:0]    mem_idx;

    // A channel in its ack cycle is masked so a held request is not served twice
    assign elig = core_req & ~core_ack;

    always_comb begin
        found = 1'b0;
        gnt = '0;
        idx = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_CORES);
            if (!found && elig[idx]) begin
                found = 1'b1;
                gnt = idx;
            end
        end
    end

    assign ptr_nxt   = (int'(gnt) == NUM_CORES - 1) ? '0 : gnt + 1'b1;
    assign sel_write = core_write[gnt];
    assign sel_addr  = core_address[int'(gnt)*ADDR_W +: ADDR_W];
    assign sel_data  = core_data_in[int'(gnt)*DATA_W +: DATA_W];
    assign in_range  = {1'b0, sel_addr} < DEPTH_X;
    assign mem_idx   = sel_addr[MEM_AW-1:0];
    assign rd_data   = in_range ? mem[mem_idx] : '0;

    // RAM contents survive reset; writes are still blocked while reset is held
    always_ff @(posedge clk) begin
        if (rst_n && found && sel_write && in_range)
            mem[mem_idx] <= sel_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr           <= '0;
            core_ack      <= '0;
            core_err      <= '0;
            core_data_out <= '0;
        end else begin
            core_ack <= '0;
            core_err <= '0;
            if (found) begin
                ptr           <= ptr_nxt;
                core_ack[gnt] <= 1'b1;
                core_err[gnt] <= !in_range;
                if (!sel_write)
                    core_data_out[int'(gnt)*DATA_W +: DATA_W] <= rd_data;
            end
        end
    end
endmodule

// File: tb/tb_shared_data_memory.sv
// tb_shared_data_memory: directed and randomized stimulus against a round-robin memory model,
// with a scoreboard queue filled at grant time and drained by an independent monitor.
module tb_shared_data_memory;
    localparam int N = 4, DW = 16, AW = 16, DEPTH = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0]    core_req, core_write, core_ack, core_err;
    logic [N*AW-1:0] core_address;
    logic [N*DW-1:0] core_data_in, core_data_out;

    logic          req  [N];
    logic          wr   [N];
    logic [AW-1:0] addr [N];
    logic [DW-1:0] din  [N];
    logic [AW-1:0] pool [10] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd5, 16'd998, 16'd999, 16'd1000, 16'd1001, 16'hFFFF};

    typedef struct {
        int core;
        logic err;
        logic [DW-1:0] data;
        bit known;
    } exp_t;

    exp_t exp_q[$];
    int   gq[$];
    logic [DW-1:0] ref_mem   [DEPTH];
    bit            ref_valid [DEPTH];
    int            ptr_m;
    bit            m_ack   [N];
    logic [DW-1:0] m_dout  [N];
    bit            m_known [N];
    int checks = 0, failures = 0;

    shared_data_memory #(.NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .core_req(core_req), .core_write(core_write),
        .core_address(core_address), .core_data_in(core_data_in),
        .core_ack(core_ack), .core_err(core_err), .core_data_out(core_data_out)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            core_req[i] = req[i];
            core_write[i] = wr[i];
            core_address[i*AW +: AW] = addr[i];
            core_data_in[i*DW +: DW] = din[i];
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(string name, int c);
        checks++;
        failures++;
        $display("FAIL %s: core%0d request not acknowledged within bound", name, c);
    endtask

    // Reference model: round-robin over held requests, one access per edge, flat memory array
    always @(posedge clk or negedge rst_n) begin : model
        int g, a;
        exp_t e;
        if (!rst_n) begin
            ptr_m = 0;
            exp_q.delete();
            for (int i = 0; i < N; i++) begin
                m_ack[i] = 0;
                m_dout[i] = '0;
                m_known[i] = 1;
            end
        end else begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && req[(ptr_m + k) % N] && !m_ack[(ptr_m + k) % N]) g = (ptr_m + k) % N;
            for (int i = 0; i < N; i++) m_ack[i] = 0;
            if (g >= 0) begin
                a = int'(addr[g]);
                if (wr[g]) begin
                    if (a < DEPTH) begin
                        ref_mem[a] = din[g];
                        ref_valid[a] = 1;
                    end
                end else begin
                    m_dout[g] = (a < DEPTH) ? ref_mem[a] : '0;
                    m_known[g] = (a < DEPTH) ? ref_valid[a] : 1'b1;
                end
                e.core = g;
                e.err = (a >= DEPTH);
                e.data = m_dout[g];
                e.known = m_known[g];
                exp_q.push_back(e);
                m_ack[g] = 1;
                ptr_m = (g + 1) % N;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            for (int i = 0; i < N; i++) if (core_ack[i]) gq.push_back(i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("ack core%0d", e.core), 64'(core_ack), 64'(1) << e.core);
                check($sformatf("err core%0d", e.core), 64'(core_err), 64'(e.err) << e.core);
                if (e.known)
                    check($sformatf("data core%0d", e.core), 64'(core_data_out[e.core*DW +: DW]), 64'(e.data));
            end else begin
                check("idle_ack", 64'(core_ack), 64'd0);
                check("idle_err", 64'(core_err), 64'd0);
            end
        end
    end

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int c, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
        req[c] = 1'b1;
        wr[c] = w;
        addr[c] = a;
        din[c] = d;
        for (int n = 0; ; n++) begin
            settle();
            if (core_ack[c]) break;
            if (n > 3 * N) begin
                timeout("issue", c);
                break;
            end
        end
        req[c] = 1'b0;
    endtask

    task automatic agent(int c, int cycles);
        int wt = 0;
        repeat (cycles) begin
            settle();
            if (req[c] && !core_ack[c]) begin
                wt++;
                if (wt > 3 * N) begin
                    timeout("agent", c);
                    req[c] = 1'b0;
                    wt = 0;
                end
            end else begin
                wt = 0;
                req[c] = ($urandom_range(0, 3) != 0);
                wr[c] = 1'($urandom_range(0, 1));
                addr[c] = pool[$urandom_range(0, 9)];
                din[c] = DW'($urandom);
            end
        end
        wt = 0;
        while (req[c] && !core_ack[c] && wt <= 3 * N) begin
            settle();
            wt++;
        end
        if (req[c] && !core_ack[c]) timeout("drain", c);
        req[c] = 1'b0;
    endtask

    function automatic int grant_code();
        int v = 0;
        foreach (gq[i]) v = v * 16 + gq[i];
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            req[i] = 1'b0;
            wr[i] = 1'b0;
            addr[i] = '0;
            din[i] = '0;
        end
        repeat (2) settle();
        check("reset_ack", 64'(core_ack), 64'd0);
        check("reset_err", 64'(core_err), 64'd0);
        check("reset_dout", core_data_out, 64'd0);
        rst_n = 1'b1;

        gq.delete();
        fork
            issue(0, 1'b0, 16'd5, 16'd0);
            issue(1, 1'b0, 16'd998, 16'd0);
            issue(2, 1'b0, 16'd1000, 16'd0);
            issue(3, 1'b0, 16'd0, 16'd0);
        join
        settle();
        check("contention_order", 64'(grant_code()), 64'h0123);

        gq.delete();
        fork
            issue(0, 1'b1, 16'd998, 16'h0007);
            issue(1, 1'b0, 16'd998, 16'd0);
        join
        check("raw_data", 64'(core_data_out[DW +: DW]), 64'h0007);
        settle();
        check("raw_order", 64'(grant_code()), 64'h01);

        issue(1, 1'b1, 16'd5, 16'h00AB);
        issue(1, 1'b0, 16'd5, 16'd0);
        check("single_rd", 64'(core_data_out[DW +: DW]), 64'h00AB);

        issue(3, 1'b1, 16'd1000, 16'h1234);
        check("oob_wr_err", 64'(core_err[3]), 64'd1);
        issue(3, 1'b0, 16'd1000, 16'd0);
        check("oob_rd_err", 64'(core_err[3]), 64'd1);
        check("oob_rd_data", 64'(core_data_out[3*DW +: DW]), 64'd0);
        issue(3, 1'b1, 16'd999, 16'h4321);
        check("edge_wr_err", 64'(core_err[3]), 64'd0);
        issue(3, 1'b0, 16'd999, 16'd0);
        check("edge_rd_err", 64'(core_err[3]), 64'd0);
        check("edge_rd_data", 64'(core_data_out[3*DW +: DW]), 64'h4321);

        gq.delete();
        fork
            repeat (4) issue(0, 1'b0, 16'd5, 16'd0);
            repeat (4) issue(2, 1'b0, 16'd998, 16'd0);
        join
        settle();
        check("fairness_order", 64'(grant_code()), 64'h02020202);

        fork
            agent(0, 300);
            agent(1, 300);
            agent(2, 300);
            agent(3, 300);
        join
        settle();

        issue(1, 1'b1, 16'd3, 16'h5A5A);
        issue(1, 1'b0, 16'd3, 16'd0);
        check("pre_rst_data", 64'(core_data_out[DW +: DW]), 64'h5A5A);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ack", 64'(core_ack), 64'd0);
        check("midrst_err", 64'(core_err), 64'd0);
        check("midrst_dout", core_data_out, 64'd0);
        for (int i = 0; i < N; i++) begin
            req[i] = 1'b1;
            wr[i] = 1'b0;
            addr[i] = 16'd3;
        end
        repeat (2) settle();
        check("inrst_ack", 64'(core_ack), 64'd0);
        gq.delete();
        rst_n = 1'b1;
        for (int n = 0; n < 4 * N; n++) begin
            settle();
            for (int i = 0; i < N; i++) if (core_ack[i]) req[i] = 1'b0;
        end
        for (int i = 0; i < N; i++) if (req[i]) timeout("post_reset", i);
        check("post_reset_order", 64'(grant_code()), 64'h0123);

        repeat (3) settle();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
